// File: rtl/ocram_pkg.sv
// rtl/ocram_pkg.sv - shared widths, depth and FSM state types for the frame-buffer scheduler
package ocram_pkg;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 24;
    localparam int NUM_PIXELS = 102400;

    typedef logic [23:0] pixel_t;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} scan_state_t;
    typedef enum logic {C_IDLE, C_RUN} clr_state_t;
endpackage

// File: rtl/ocram_scheduler_if.sv
// rtl/ocram_scheduler_if.sv - rasterizer, clear, scanout and RAM signals of the scheduler
interface ocram_scheduler_if #(
    parameter int ADDR_W = ocram_pkg::ADDR_W,
    parameter int DATA_W = ocram_pkg::DATA_W
);
    logic              raster_req;
    logic [ADDR_W-1:0] raster_addr;
    logic [DATA_W-1:0] raster_data;
    logic              raster_ack;
    logic              clear_start;
    logic [DATA_W-1:0] clear_color;
    logic              clear_busy;
    logic              frame_start;
    logic              scan_busy;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_q;

    // master is the scheduler itself; slave is the surrounding rasterizer/display/RAM side
    modport master (
        input  raster_req, raster_addr, raster_data, clear_start, clear_color,
               frame_start, pix_ready, ram_q,
        output raster_ack, clear_busy, scan_busy, pix_data, pix_valid, pix_last,
               ram_we, ram_waddr, ram_wdata, ram_raddr
    );
    modport slave (
        output raster_req, raster_addr, raster_data, clear_start, clear_color,
               frame_start, pix_ready, ram_q,
        input  raster_ack, clear_busy, scan_busy, pix_data, pix_valid, pix_last,
               ram_we, ram_waddr, ram_wdata, ram_raddr
    );
endinterface

// File: rtl/ocram_skid_fifo.sv
// rtl/ocram_skid_fifo.sv - fall-through skid FIFO; an empty FIFO presents the pushed word the same cycle
module ocram_skid_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_push_data,
    input  logic             i_pop,
    output logic [W-1:0]     o_head_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty     = (r_count == '0);
    // a word pushed into an empty FIFO and popped in the same cycle is never stored
    assign w_wr        = i_push & ~(w_empty & i_pop);
    assign w_rd        = i_pop & ~w_empty;
    assign o_valid     = ~w_empty | i_push;
    assign o_head_data = w_empty ? i_push_data : r_mem[r_rd_ptr];
    assign o_count     = r_count;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
        end
    end
endmodule

// File: rtl/ocram_scheduler.sv
// rtl/ocram_scheduler.sv - frame-buffer write arbitration, clear fill and scanout read sequencing
// Optional OCRAM_SCHED_RD_BYPASS_EN forwards a colliding write to the scanout stream.
module ocram_scheduler #(
    parameter int NUM_PIXELS = ocram_pkg::NUM_PIXELS,
    parameter int ADDR_W     = ocram_pkg::ADDR_W,
    parameter int DATA_W     = ocram_pkg::DATA_W,
    parameter int SKID_DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    ocram_scheduler_if.master bus
);
    import ocram_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    clr_state_t        r_clr_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [DATA_W-1:0] r_clr_color;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    scan_state_t       r_scan_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_clear_busy;
    logic              w_raster_ack;
    logic              w_in_range;
    logic              w_issue;
    logic              w_pop;
    logic              w_pix_valid;
    logic [DATA_W-1:0] w_push_data;
    logic [DATA_W:0]   w_head;
    logic [CNT_W-1:0]  w_count;
    logic [OCC_W-1:0]  w_occ;
    logic [OCC_W-1:0]  w_lim;

    assign w_clear_busy = (r_clr_state == C_RUN);
    assign w_raster_ack = bus.raster_req & ~w_clear_busy;
    assign w_in_range   = 32'(bus.raster_addr) < NUM_PIXELS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_state <= C_IDLE;
            r_clr_addr  <= '0;
            r_clr_color <= '0;
        end else begin
            case (r_clr_state)
                C_IDLE: if (bus.clear_start) begin
                    r_clr_color <= bus.clear_color;
                    r_clr_addr  <= '0;
                    r_clr_state <= C_RUN;
                end
                C_RUN: begin
                    if (r_clr_addr == LAST_ADDR) begin
                        r_clr_addr  <= '0;
                        r_clr_state <= C_IDLE;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                default: r_clr_state <= C_IDLE;
            endcase
        end
    end

    // clear owns the write port outright; out-of-range raster writes are acked but dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_clear_busy) begin
            r_we    <= 1'b1;
            r_waddr <= r_clr_addr;
            r_wdata <= r_clr_color;
        end else begin
            r_we <= w_raster_ack & w_in_range;
            if (w_raster_ack) begin
                r_waddr <= bus.raster_addr;
                r_wdata <= bus.raster_data;
            end
        end
    end

    // occupancy counts the read already in flight so the FIFO can never overflow
    assign w_pop   = w_pix_valid & bus.pix_ready;
    assign w_occ   = OCC_W'(w_count) + OCC_W'(r_inflight);
    assign w_lim   = OCC_W'(SKID_DEPTH) + OCC_W'(w_pop);
    assign w_issue = (r_scan_state == S_SCAN) && (w_occ < w_lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_state    <= S_IDLE;
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_addr == LAST_ADDR);
            case (r_scan_state)
                S_IDLE: if (bus.frame_start) begin
                    r_rd_addr    <= '0;
                    r_scan_state <= S_SCAN;
                end
                S_SCAN: if (w_issue) begin
                    if (r_rd_addr == LAST_ADDR) r_scan_state <= S_DRAIN;
                    else                        r_rd_addr    <= r_rd_addr + 1'b1;
                end
                S_DRAIN: if (w_pop && w_head[DATA_W]) r_scan_state <= S_IDLE;
                default: r_scan_state <= S_IDLE;
            endcase
        end
    end

`ifdef OCRAM_SCHED_RD_BYPASS_EN
    logic              r_byp_hit;
    logic [DATA_W-1:0] r_byp_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_hit  <= w_issue && r_we && (r_waddr == r_rd_addr);
            r_byp_data <= r_wdata;
        end
    end

    assign w_push_data = r_byp_hit ? r_byp_data : bus.ram_q;
`else
    assign w_push_data = bus.ram_q;
`endif

    ocram_skid_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (SKID_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, w_push_data}),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_valid     (w_pix_valid),
        .o_count     (w_count)
    );

    assign bus.raster_ack = w_raster_ack;
    assign bus.clear_busy = w_clear_busy;
    assign bus.scan_busy  = (r_scan_state != S_IDLE);
    assign bus.pix_data   = w_head[DATA_W-1:0];
    assign bus.pix_last   = w_pix_valid & w_head[DATA_W];
    assign bus.pix_valid  = w_pix_valid;
    assign bus.ram_we     = r_we;
    assign bus.ram_waddr  = r_waddr;
    assign bus.ram_wdata  = r_wdata;
    assign bus.ram_raddr  = r_rd_addr;
endmodule

// File: doc/ocram_scheduler.md
Name: ocram_scheduler

Overview:
- Sequences and shares the output-controller frame-buffer RAM: one registered-read M9K array, 24-bit pixels, 17-bit addresses, 102400 entries.
- Arbitrates the single write port between rasterizer pixel writes and an internal clear-fill engine.
- Generates read addresses for display scanout and absorbs the RAM's 1-cycle read latency behind a valid/ready stream with a small skid buffer.

Parameters:
- NUM_PIXELS, 102400, frame-buffer depth; last valid address = NUM_PIXELS-1.
- ADDR_W, 17, RAM address width.
- DATA_W, 24, pixel width (RGB888).
- SKID_DEPTH, 2, scanout output buffer entries; minimum 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- raster_req  in  1  rasterizer write request.
- raster_addr  in  ADDR_W  rasterizer pixel address.
- raster_data  in  DATA_W  rasterizer pixel value.
- raster_ack  out  1  combinational; request accepted this cycle.
- clear_start  in  1  1-cycle pulse; fill the whole buffer with clear_color.
- clear_color  in  DATA_W  sampled on an accepted clear_start.
- clear_busy  out  1  clear engine active.
- frame_start  in  1  1-cycle pulse; begin scanout of one frame.
- scan_busy  out  1  scanout in progress.
- pix_data  out  DATA_W  scanout pixel, skid buffer head.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  consumer ready.
- pix_last  out  1  head is address NUM_PIXELS-1.
- ram_we  out  1  registered RAM write enable.
- ram_waddr  out  ADDR_W  registered write address.
- ram_wdata  out  DATA_W  registered write data.
- ram_raddr  out  ADDR_W  combinational read address.
- ram_q  in  DATA_W  RAM read data; valid the cycle after a read issue.

Behaviour:
- Reset values: all outputs 0; both FSMs idle; skid buffer empty; counters 0.
- Write arbitration:
  - Clear engine has absolute priority.
  - raster_ack = raster_req & ~clear_busy.
  - Accepted raster write appears on ram_we/waddr/wdata the next cycle (1-cycle latency).
  - raster_addr >= NUM_PIXELS: still acked; ram_we stays 0 (write dropped).
- Clear FSM C_IDLE -> C_RUN:
  - Transition on clear_start: latch clear_color, clr_addr = 0.
  - C_RUN writes one pixel per cycle: clr_addr 0..NUM_PIXELS-1.
  - Returns to C_IDLE after issuing address NUM_PIXELS-1; exactly NUM_PIXELS ram_we cycles.
  - clear_busy is high from the cycle after clear_start through the cycle issuing the last write.
  - clear_start while in C_RUN is ignored.
  - If raster_req and clear_start occur in the same cycle, the raster write is acked; the clear starts next cycle.
- Scan FSM S_IDLE -> S_SCAN -> S_DRAIN -> S_IDLE:
  - frame_start in S_IDLE: rd_addr = 0, go to S_SCAN. frame_start outside S_IDLE is ignored.
  - S_SCAN: issue a read (ram_raddr = rd_addr, rd_addr++) when fifo_count + inflight - pop < SKID_DEPTH. pop = pix_valid & pix_ready; inflight = read issued in the previous cycle.
  - After issuing NUM_PIXELS-1, go to S_DRAIN.
  - S_DRAIN: go to S_IDLE once the last pixel (pix_last) is popped.
  - scan_busy = state != S_IDLE.
  - ram_q is pushed into the skid FIFO the cycle after an issue. Push and pop in the same cycle are allowed; no data loss; no bubble at full throughput.
  - With pix_ready held high, pix_valid first rises 2 cycles after frame_start; sustained rate is 1 pixel/cycle.
- Clear and scan run concurrently. Read-during-write to the same address returns OLD data unless the optional feature is enabled.
- rst mid-operation: both FSMs abort to idle, skid buffer flushed, pix_valid drops asynchronously.

Optional Feature:
- Macro: OCRAM_SCHED_RD_BYPASS_EN.
- Defined: when a read issues while the registered ram_we=1 and ram_waddr==ram_raddr, register ram_wdata and substitute it for ram_q on the following push. Scanout then sees the new pixel.
- Undefined: no comparator; RAM old-data semantics pass through.

Decomposition:
- Package ocram_pkg: ADDR_W/DATA_W/NUM_PIXELS localparams; pixel_t (logic [23:0]); scan_state_t {S_IDLE,S_SCAN,S_DRAIN}; clr_state_t {C_IDLE,C_RUN}.
- Sub-module ocram_skid_fifo (SKID_DEPTH entries, push/pop/count, simultaneous push-pop) is instantiated once for scanout.

Test Plan:
- Reset, then raster_req with addr 5, data 24'hABCDEF -> raster_ack same cycle; next cycle ram_we=1, waddr=5, wdata=24'hABCDEF.
- clear_start with clear_color 24'h00FF00 -> exactly 102400 consecutive ram_we cycles over addrs 0..102399; concurrent raster_req gets ack=0 throughout; ack resumes the cycle after the last clear write.
- frame_start with pix_ready=1 -> pix_valid 2 cycles later; 102400 beats in order; pix_last on beat 102399; scan_busy falls the cycle after.
- frame_start with pix_ready toggled 1,0,0,1 pseudo-randomly -> no dropped or duplicated pixels vs. model; fifo_count never exceeds 2.
- raster write to addr 102400 -> ack=1, ram_we stays 0.
- Assert rst mid-scan at pixel 500 -> pix_valid and scan_busy 0 immediately; new frame_start restarts at address 0. With OCRAM_SCHED_RD_BYPASS_EN, a same-address collision returns the new data.
